lcd_win_ctrl: RTL and testbench

//  Parametrised image display controller, successor to the fixed 12x9 / 4x4 LCD controller.

---
 rtl/lcd_win_ctrl_if.sv | 31 +++
 rtl/lcd_win_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_lcd_win_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_win_ctrl_if.sv
// Host/LCD-side bundle for lcd_win_ctrl: command port, load data and window output stream.
interface lcd_win_ctrl_if #(
  parameter int unsigned DW = 8
);
  logic [DW-1:0] datain;
  logic [2:0]    cmd;
  logic          cmd_valid;
  logic [DW-1:0] dataout;
  logic          output_valid;
  logic          busy;

  // Host side: issues commands and load data, consumes the window stream.
  modport master (
    output datain,
    output cmd,
    output cmd_valid,
    input  dataout,
    input  output_valid,
    input  busy
  );

  // Controller side.
  modport slave (
    input  datain,
    input  cmd,
    input  cmd_valid,
    output dataout,
    output output_valid,
    output busy
  );
endinterface

// File: rtl/lcd_win_ctrl.sv
// lcd_win_ctrl: loads an IMG_W x IMG_H raster into a buffer and streams a WIN x WIN window,
// either subsampled (fit) or 1:1 with a shiftable origin (zoom).
// Optional feature: define MIRROR_EN to make cmd 7 toggle right-to-left row output;
// without it cmd 7 is a one-cycle no-op.
module lcd_win_ctrl #(
  parameter int unsigned DW    = 8,
  parameter int unsigned IMG_W = 12,
  parameter int unsigned IMG_H = 9,
  parameter int unsigned WIN   = 4
) (
  input logic           clk,
  input logic           reset,
  lcd_win_ctrl_if.slave bus
);

  localparam int unsigned N      = IMG_W * IMG_H;
  localparam int unsigned AW     = $clog2(N);
  localparam int unsigned NB     = WIN * WIN;
  localparam int unsigned BW     = $clog2(NB + 1);
  localparam int unsigned RW     = $clog2(WIN);
  localparam int unsigned SX     = IMG_W / WIN;
  localparam int unsigned SY     = IMG_H / WIN;
  localparam int unsigned OX_MAX = IMG_W - WIN;
  localparam int unsigned OY_MAX = IMG_H - WIN;
  localparam int unsigned OX_C   = (IMG_W - WIN + 1) / 2;
  localparam int unsigned OY_C   = (IMG_H - WIN + 1) / 2;

  localparam logic [2:0] CmdLoad   = 3'd0;
  localparam logic [2:0] CmdZoomIn = 3'd1;
  localparam logic [2:0] CmdFit    = 3'd2;
  localparam logic [2:0] CmdRight  = 3'd3;
  localparam logic [2:0] CmdLeft   = 3'd4;
  localparam logic [2:0] CmdUp     = 3'd5;
  localparam logic [2:0] CmdDown   = 3'd6;
  localparam logic [2:0] CmdMirror = 3'd7;

  typedef enum logic [1:0] {StIdle, StLoad, StPrep, StOut} state_e;

  state_e          state_q, state_d;
  logic            zoom_q, zoom_d;
  logic            loaded_q, loaded_d;
  logic            mirror_q, mirror_d;
  logic            skip_q, skip_d;
  logic [AW-1:0]   ox_q, ox_d;
  logic [AW-1:0]   oy_q, oy_d;
  logic [AW-1:0]   lcnt_q, lcnt_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [RW-1:0]   row_q, row_d;
  logic [RW-1:0]   col_q, col_d;
  logic [DW-1:0]   dataout_q, dataout_d;
  logic            ovalid_q, ovalid_d;

  // Pixel buffer: deliberately not reset; loaded_q says whether it holds a valid image.
  logic [DW-1:0]   mem_q [N];

  logic [AW-1:0]   row_a, col_a, addr;

  // Buffer address of the current beat for the active mode and mirror setting.
  always_comb begin
    row_a = AW'(row_q);
    col_a = mirror_q ? (AW'(WIN - 1) - AW'(col_q)) : AW'(col_q);
    if (zoom_q) begin
      addr = (oy_q + row_a) * AW'(IMG_W) + ox_q + col_a;
    end else begin
      addr = (AW'(SY / 2) + row_a * AW'(SY)) * AW'(IMG_W) + AW'(SX / 2) + col_a * AW'(SX);
    end
  end

  // Buffer write port, active only while a LOAD is streaming in.
  always_ff @(posedge clk) begin
    if (state_q == StLoad) begin
      mem_q[lcnt_q] <= bus.datain;
    end
  end

  // Sequencer next state, view-state updates and output beat generation.
  always_comb begin
    state_d   = state_q;
    zoom_d    = zoom_q;
    loaded_d  = loaded_q;
    mirror_d  = mirror_q;
    skip_d    = skip_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    lcnt_d    = lcnt_q;
    bcnt_d    = bcnt_q;
    row_d     = row_q;
    col_d     = col_q;
    dataout_d = dataout_q;
    ovalid_d  = ovalid_q;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          skip_d  = 1'b0;
          state_d = StPrep;
          unique case (bus.cmd)
            CmdLoad: begin
              state_d = StLoad;
              lcnt_d  = '0;
            end
            CmdZoomIn: begin
              // Entering zoom recentres; re-issuing in zoom keeps the origin.
              if (!zoom_q) begin
                zoom_d = 1'b1;
                ox_d   = AW'(OX_C);
                oy_d   = AW'(OY_C);
              end
            end
            CmdFit: zoom_d = 1'b0;
            CmdRight: if (zoom_q && ox_q != AW'(OX_MAX)) ox_d = ox_q + 1'b1;
            CmdLeft:  if (zoom_q && ox_q != '0) ox_d = ox_q - 1'b1;
            CmdUp:    if (zoom_q && oy_q != '0) oy_d = oy_q - 1'b1;
            CmdDown:  if (zoom_q && oy_q != AW'(OY_MAX)) oy_d = oy_q + 1'b1;
            CmdMirror: begin
`ifdef MIRROR_EN
              mirror_d = ~mirror_q;
`else
              skip_d = 1'b1;
`endif
            end
            default: ;
          endcase
        end
      end
      StLoad: begin
        if (lcnt_q == AW'(N - 1)) begin
          loaded_d = 1'b1;
          zoom_d   = 1'b0;
          mirror_d = 1'b0;
          state_d  = StPrep;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      StPrep: begin
        bcnt_d  = '0;
        row_d   = '0;
        col_d   = '0;
        state_d = skip_q ? StIdle : StOut;
      end
      StOut: begin
        if (bcnt_q == BW'(NB)) begin
          // busy and output_valid drop on the same edge.
          ovalid_d = 1'b0;
          state_d  = StIdle;
        end else begin
          dataout_d = loaded_q ? mem_q[addr] : '0;
          ovalid_d  = 1'b1;
          bcnt_d    = bcnt_q + 1'b1;
          if (col_q == RW'(WIN - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset discards any partial load and recentres the zoom origin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      zoom_q    <= 1'b0;
      loaded_q  <= 1'b0;
      mirror_q  <= 1'b0;
      skip_q    <= 1'b0;
      ox_q      <= AW'(OX_C);
      oy_q      <= AW'(OY_C);
      lcnt_q    <= '0;
      bcnt_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      dataout_q <= '0;
      ovalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      zoom_q    <= zoom_d;
      loaded_q  <= loaded_d;
      mirror_q  <= mirror_d;
      skip_q    <= skip_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      lcnt_q    <= lcnt_d;
      bcnt_q    <= bcnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      dataout_q <= dataout_d;
      ovalid_q  <= ovalid_d;
    end
  end

  assign bus.dataout      = dataout_q;
  assign bus.output_valid = ovalid_q;
  assign bus.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Directed bench for lcd_win_ctrl at default parameters (12x9 image, 4x4 window).
// Define MIRROR_EN for both RTL and bench to exercise the mirror feature.
module tb_lcd_win_ctrl;

  localparam logic [2:0] CLOAD = 3'd0, CZOOM = 3'd1, CFIT = 3'd2, CRIGHT = 3'd3;
  localparam logic [2:0] CLEFT = 3'd4, CUP = 3'd5, CDOWN = 3'd6, CMIR = 3'd7;

  logic clk;
  logic reset;
  lcd_win_ctrl_if #(.DW(8)) bus ();

  lcd_win_ctrl #(.DW(8), .IMG_W(12), .IMG_H(9), .WIN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [7:0] got [$];
  int busy_n;
  bit ovl_err;

  // Fit window for a 0..107 ramp: SX=3, SY=2 -> (1+2r)*12 + 1 + 3c.
  logic [7:0] fit_exp [16] = '{13, 16, 19, 22, 37, 40, 43, 46,
                               61, 64, 67, 70, 85, 88, 91, 94};
  // Zoom window offsets from the top-left pixel for a 12-wide image.
  int zoom_off [16] = '{0, 1, 2, 3, 12, 13, 14, 15, 24, 25, 26, 27, 36, 37, 38, 39};

  // Issue one command and collect beats until busy drops (bounded).
  task automatic run_cmd(input logic [2:0] c, input int pulse_at);
    @(negedge clk);
    bus.cmd       = c;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd       = CRIGHT;
    got.delete();
    busy_n  = 0;
    ovl_err = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (c == CLOAD && cyc < 108) bus.datain = 8'(cyc);
      if (!bus.busy) begin
        if (bus.output_valid) ovl_err = 1'b1;
        break;
      end
      busy_n++;
      if (bus.output_valid) got.push_back(bus.dataout);
      bus.cmd_valid = (cyc == pulse_at);
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.datain = '0;
    bus.cmd = '0;
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.dataout !== 8'd0 || bus.output_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL reset_held: dout=%0d ov=%b busy=%b, need 0/0/0",
               bus.dataout, bus.output_valid, bus.busy);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.output_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL reset_release: ov=%b busy=%b, need 0/0", bus.output_valid, bus.busy);
    else passed++;
  endtask

  task automatic test_unloaded();
    run_cmd(CZOOM, -1);
    checks++;
    if (got.size() != 16 || busy_n != 18 || ovl_err)
      $display("FAIL unloaded_len: beats=%0d busy=%0d ovl=%b, need 16/18/0",
               got.size(), busy_n, ovl_err);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== 8'd0)
        $display("FAIL unloaded_beat%0d: got %0d, need 0", i, (i < got.size()) ? got[i] : 8'hxx);
      else passed++;
    end
  endtask

  task automatic test_load();
    run_cmd(CLOAD, -1);
    checks++;
    if (got.size() != 16 || busy_n != 126 || ovl_err)
      $display("FAIL load_len: beats=%0d busy=%0d ovl=%b, need 16/126/0",
               got.size(), busy_n, ovl_err);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== fit_exp[i])
        $display("FAIL load_fit_beat%0d: got %0d, need %0d",
                 i, (i < got.size()) ? got[i] : 8'hxx, fit_exp[i]);
      else passed++;
    end
  endtask

  task automatic test_zoom();
    for (int rep = 0; rep < 2; rep++) begin
      run_cmd(CZOOM, -1);
      checks++;
      if (got.size() != 16 || busy_n != 18)
        $display("FAIL zoom%0d_len: beats=%0d busy=%0d, need 16/18", rep, got.size(), busy_n);
      else passed++;
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (i >= got.size() || got[i] !== 8'(40 + zoom_off[i]))
          $display("FAIL zoom%0d_beat%0d: got %0d, need %0d",
                   rep, i, (i < got.size()) ? got[i] : 8'hxx, 40 + zoom_off[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_pan_horiz();
    repeat (5) run_cmd(CRIGHT, -1);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== 8'(44 + zoom_off[i]))
        $display("FAIL right_sat_beat%0d: got %0d, need %0d",
                 i, (i < got.size()) ? got[i] : 8'hxx, 44 + zoom_off[i]);
      else passed++;
    end
    run_cmd(CFIT, -1);
    run_cmd(CZOOM, -1);
    repeat (5) run_cmd(CLEFT, -1);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== 8'(36 + zoom_off[i]))
        $display("FAIL left_sat_beat%0d: got %0d, need %0d",
                 i, (i < got.size()) ? got[i] : 8'hxx, 36 + zoom_off[i]);
      else passed++;
    end
  endtask

  task automatic test_pan_vert_fit();
    run_cmd(CFIT, -1);
    run_cmd(CZOOM, -1);
    repeat (4) run_cmd(CUP, -1);
    checks++;
    if (got.size() != 16 || got[0] !== 8'd4 || got[15] !== 8'd43)
      $display("FAIL up_sat: first=%0d last=%0d, need 4/43",
               (got.size() > 0) ? got[0] : 8'hxx, (got.size() > 15) ? got[15] : 8'hxx);
    else passed++;
    repeat (6) run_cmd(CDOWN, -1);
    checks++;
    if (got.size() != 16 || got[0] !== 8'd64 || got[15] !== 8'd103)
      $display("FAIL down_sat: first=%0d last=%0d, need 64/103",
               (got.size() > 0) ? got[0] : 8'hxx, (got.size() > 15) ? got[15] : 8'hxx);
    else passed++;
    run_cmd(CFIT, -1);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== fit_exp[i])
        $display("FAIL refit_beat%0d: got %0d, need %0d",
                 i, (i < got.size()) ? got[i] : 8'hxx, fit_exp[i]);
      else passed++;
    end
    // Shift in fit mode: no movement, fit window again.
    run_cmd(CRIGHT, -1);
    checks++;
    if (got.size() != 16 || got[0] !== 8'd13 || got[15] !== 8'd94 || busy_n != 18)
      $display("FAIL fit_shift: beats=%0d first=%0d last=%0d, need 16/13/94",
               got.size(), (got.size() > 0) ? got[0] : 8'hxx,
               (got.size() > 15) ? got[15] : 8'hxx);
    else passed++;
  endtask

  task automatic test_busy_ignore();
    run_cmd(CZOOM, 5);
    checks++;
    if (got.size() != 16 || busy_n != 18 || got[0] !== 8'd40)
      $display("FAIL busy_pulse_run: beats=%0d busy=%0d first=%0d, need 16/18/40",
               got.size(), busy_n, (got.size() > 0) ? got[0] : 8'hxx);
    else passed++;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.output_valid !== 1'b0)
      $display("FAIL busy_pulse_idle: busy=%b ov=%b, need 0/0", bus.busy, bus.output_valid);
    else passed++;
    run_cmd(CZOOM, -1);
    checks++;
    if (got.size() != 16 || got[0] !== 8'd40 || got[15] !== 8'd79)
      $display("FAIL busy_pulse_origin: first=%0d last=%0d, need 40/79",
               (got.size() > 0) ? got[0] : 8'hxx, (got.size() > 15) ? got[15] : 8'hxx);
    else passed++;
  endtask

  task automatic test_mirror();
`ifdef MIRROR_EN
    logic [7:0] mir_exp [16] = '{43, 42, 41, 40, 55, 54, 53, 52,
                                 67, 66, 65, 64, 79, 78, 77, 76};
    run_cmd(CMIR, -1);
    checks++;
    if (got.size() != 16 || busy_n != 18)
      $display("FAIL mirror_len: beats=%0d busy=%0d, need 16/18", got.size(), busy_n);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== mir_exp[i])
        $display("FAIL mirror_beat%0d: got %0d, need %0d",
                 i, (i < got.size()) ? got[i] : 8'hxx, mir_exp[i]);
      else passed++;
    end
    run_cmd(CMIR, -1);
    checks++;
    if (got.size() != 16 || got[0] !== 8'd40 || got[3] !== 8'd43)
      $display("FAIL mirror_off: beat0=%0d beat3=%0d, need 40/43",
               (got.size() > 0) ? got[0] : 8'hxx, (got.size() > 3) ? got[3] : 8'hxx);
    else passed++;
`else
    run_cmd(CMIR, -1);
    checks++;
    if (got.size() != 0 || busy_n != 1 || ovl_err)
      $display("FAIL mirror_nop: beats=%0d busy=%0d, need 0/1", got.size(), busy_n);
    else passed++;
    run_cmd(CZOOM, -1);
    checks++;
    if (got.size() != 16 || got[0] !== 8'd40 || got[3] !== 8'd43)
      $display("FAIL mirror_nop_state: beat0=%0d beat3=%0d, need 40/43",
               (got.size() > 0) ? got[0] : 8'hxx, (got.size() > 3) ? got[3] : 8'hxx);
    else passed++;
`endif
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    @(negedge clk);
    bus.cmd       = CZOOM;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 40 && seen < 7; cyc++) begin
      if (bus.output_valid) seen++;
      if (seen < 7) @(negedge clk);
    end
    checks++;
    if (seen != 7) $display("FAIL mid_reach_beat7: saw %0d beats, need 7", seen);
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.output_valid !== 1'b0 || bus.busy !== 1'b0 || bus.dataout !== 8'd0)
      $display("FAIL mid_reset_async: ov=%b busy=%b dout=%0d, need 0/0/0",
               bus.output_valid, bus.busy, bus.dataout);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    // After reset the image is gone: fit->zoom yields zeros.
    run_cmd(CZOOM, -1);
    checks++;
    if (got.size() != 16 || got[0] !== 8'd0 || got[15] !== 8'd0 || busy_n != 18)
      $display("FAIL mid_reset_unloaded: beats=%0d first=%0d last=%0d, need 16/0/0",
               got.size(), (got.size() > 0) ? got[0] : 8'hxx,
               (got.size() > 15) ? got[15] : 8'hxx);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_unloaded();
    test_load();
    test_zoom();
    test_pan_horiz();
    test_pan_vert_fit();
    test_busy_ignore();
    test_mirror();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
